// File: rtl/mmio_timer_if.sv
// AXI4-Lite bundle between the CPU mmio master port and the machine timer.
interface mmio_timer_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mmio_timer.sv
// Machine timer: free-running 64-bit mtime behind a 16-bit prescaler, a 64-bit
// mtimecmp and a registered level irq, on an AXI4-Lite slave with independent
// read and write channel FSMs.
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    mmio_timer_if.slave bus,
    output logic        irq
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] MAP_END     = 32'h0000_0018;

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_PRESCALE = 3'd5;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_rsp_t;

    // Timer state
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic        ie;
    logic [15:0] prescale;
    logic [15:0] pc;
    logic [31:0] snap;
    logic        tick;
    logic        hit;

    // Bus decode
    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [31:0] wr_off, rd_off;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_hit, rd_hit;
    logic        wr_go, rd_go;
    logic        wr_map;
    logic        we_mtime_lo, we_mtime_hi, we_cmp_lo, we_cmp_hi, we_ctrl, we_pre;
    rd_rsp_t     rd_rsp;

    // Byte-strobe merge of a write into a 32-bit register image.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
        return res;
    endfunction

    // Offsets are relative to BASE; anything at or past 0x18 (including
    // addresses below BASE, which wrap high) is unmapped.
    assign wr_off = bus.awaddr - BASE;
    assign rd_off = bus.araddr - BASE;
    assign wr_idx = wr_off[4:2];
    assign rd_idx = rd_off[4:2];
    assign wr_hit = (wr_off < MAP_END);
    assign rd_hit = (rd_off < MAP_END);

    // AW and W are only ever taken together; reset masks acceptance so the
    // ready outputs read 0 while aresetn is low.
    assign wr_go  = (w_state == W_IDLE) & bus.awvalid & bus.wvalid & aresetn;
    assign rd_go  = (r_state == R_IDLE) & bus.arvalid & aresetn;

    assign wr_map      = wr_go & wr_hit;
    assign we_mtime_lo = wr_map & (wr_idx == IDX_MTIME_LO);
    assign we_mtime_hi = wr_map & (wr_idx == IDX_MTIME_HI);
    assign we_cmp_lo   = wr_map & (wr_idx == IDX_CMP_LO);
    assign we_cmp_hi   = wr_map & (wr_idx == IDX_CMP_HI);
    assign we_ctrl     = wr_map & (wr_idx == IDX_CTRL);
    assign we_pre      = wr_map & (wr_idx == IDX_PRESCALE);

    assign tick = en & (pc == prescale);
    assign hit  = (mtime >= mtimecmp);

    // Channel FSM state registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Channel FSM next-state: leave RESP only on the response handshake
    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:  if (wr_go)      w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default:                 w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  if (rd_go)      r_next = R_RESP;
            R_RESP:  if (bus.rready) r_next = R_IDLE;
            default:                 r_next = R_IDLE;
        endcase
    end

    // Channel FSM outputs: readies in IDLE, valids in RESP
    always_comb begin
        bus.awready = wr_go;
        bus.wready  = wr_go;
        bus.bvalid  = (w_state == W_RESP);
        bus.arready = (r_state == R_IDLE) & aresetn;
        bus.rvalid  = (r_state == R_RESP);
    end

    // Write response code, captured at acceptance and held through RESP
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   bus.bresp <= RESP_OKAY;
        else if (wr_go) bus.bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
    end

    // Prescaler: wraps at PRESCALE, restarts on any CTRL/PRESCALE write
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)               pc <= '0;
        else if (we_ctrl || we_pre) pc <= '0;
        else if (tick)              pc <= '0;
        else if (en)                pc <= pc + 16'd1;
    end

    // mtime: a bus write to either half wins over the tick and blocks any
    // carry into the other half for that cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)         mtime         <= '0;
        else if (we_mtime_lo) mtime[31:0]   <= merge(mtime[31:0], bus.wdata, bus.wstrb);
        else if (we_mtime_hi) mtime[63:32]  <= merge(mtime[63:32], bus.wdata, bus.wstrb);
        else if (tick)        mtime         <= mtime + 64'd1;
    end

    // mtimecmp halves
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mtimecmp <= '1;
        end else begin
            if (we_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus.wdata, bus.wstrb);
            if (we_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.wdata, bus.wstrb);
        end
    end

    // CTRL and PRESCALE; only the implemented bytes are strobe-sensitive
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
        end else begin
            if (we_ctrl && bus.wstrb[0]) begin
                en <= bus.wdata[0];
                ie <= bus.wdata[1];
            end
            if (we_pre && bus.wstrb[0]) prescale[7:0]  <= bus.wdata[7:0];
            if (we_pre && bus.wstrb[1]) prescale[15:8] <= bus.wdata[15:8];
        end
    end

    // Read mux over pre-write register values
    always_comb begin
        rd_rsp.data = '0;
        rd_rsp.resp = RESP_OKAY;
        if (!rd_hit) begin
            rd_rsp.resp = RESP_SLVERR;
        end else begin
            case (rd_idx)
                IDX_MTIME_LO: rd_rsp.data = mtime[31:0];
                IDX_MTIME_HI: rd_rsp.data = snap;
                IDX_CMP_LO:   rd_rsp.data = mtimecmp[31:0];
                IDX_CMP_HI:   rd_rsp.data = mtimecmp[63:32];
                IDX_CTRL:     rd_rsp.data = {30'd0, ie, en};
                IDX_PRESCALE: rd_rsp.data = {16'd0, prescale};
                default:      rd_rsp.data = '0;
            endcase
        end
    end

    // Read data capture; a MTIME_LO read latches the high word of the same
    // cycle so a following MTIME_HI read pairs with it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.rdata <= '0;
            bus.rresp <= RESP_OKAY;
            snap      <= '0;
        end else if (rd_go) begin
            bus.rdata <= rd_rsp.data;
            bus.rresp <= rd_rsp.resp;
            if (rd_hit && (rd_idx == IDX_MTIME_LO)) snap <= mtime[63:32];
        end
    end

    // Registered level interrupt
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) irq <= 1'b0;
        else          irq <= ie & hit;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Machine timer peripheral on the CPU's `mmio` AXI4-Lite master port; it generates the CPU's `irq` input. It holds a free-running 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register, and control bits. It raises a level interrupt while `mtime >= mtimecmp` and the interrupt enable is set. Software clears the interrupt by rewriting `mtimecmp` or clearing the enable.

## Interface
- `BASE`, default 32'h0000_0000: byte address of register 0; the block decodes `addr - BASE`.
- `aclk` input 1: single clock; all state is on the rising edge.
- `aresetn` input 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronized externally.
- `bus` axi.slave: AXI4-Lite slave, 32-bit address, 32-bit data, 4-bit `wstrb`. Channels used: AW, W, B, AR, R. `resp` values: OKAY = 2'b00, SLVERR = 2'b10.
- `irq` output 1: registered timer interrupt, level-sensitive.

## Operation
- Register map (offset from `BASE`, word-aligned; address bits [1:0] are ignored):
  - 0x00 `MTIME_LO`: RW.
  - 0x04 `MTIME_HI`: RW; a read returns the snapshot.
  - 0x08 `MTIMECMP_LO`: RW.
  - 0x0C `MTIMECMP_HI`: RW.
  - 0x10 `CTRL`: bit0 = `en` (count), bit1 = `ie` (irq enable); other bits read 0.
  - 0x14 `PRESCALE`: 16-bit RW; upper bits read 0.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `CTRL` = 0, `PRESCALE` = 0, snapshot = 0.
  - `irq` = 0.
  - All `ready`/`valid` outputs = 0, `rdata` = 0, `bresp`/`rresp` = 0.
- Prescaler:
  - 16-bit counter `pc`. When `en` = 1: if `pc == PRESCALE`, then `pc` ← 0 and `mtime` increments; otherwise `pc` increments.
  - `PRESCALE` = 0 means `mtime` increments every cycle.
  - When `en` = 0, `pc` holds its value.
  - Any write to `PRESCALE` or `CTRL` clears `pc`.
- `mtime` increments modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- If a bus write to `MTIME_LO` or `MTIME_HI` and an increment occur in the same cycle, the write wins for the written half. The other half keeps its old value, with no carry applied.
- Byte strobes: each `wstrb[i]` enables byte i of the target register. `wstrb` = 0 is a legal no-op that still returns OKAY.
- Snapshot: a read of `MTIME_LO` returns the live low word and latches the live high word, both from the same cycle. A read of `MTIME_HI` returns the latched word.
- Compare: `hit = (mtime >= mtimecmp)`, a 64-bit unsigned compare. `irq` is registered as `ie & hit`.
- Offsets ≥ 0x18 are unmapped:
  - Writes are dropped and return `bresp` = SLVERR.
  - Reads return `rdata` = 0 with `rresp` = SLVERR.
- Write FSM:
  - States W_IDLE and W_RESP.
  - In W_IDLE, `awready` and `wready` are driven together, both high only in the cycle where `awvalid & wvalid`. Neither channel is accepted alone.
  - On acceptance, the register is updated in that cycle and the FSM moves to W_RESP.
  - In W_RESP, `bvalid` = 1 and `bresp` is held stable. The FSM returns to W_IDLE on `bvalid & bready`.
- Read FSM:
  - States R_IDLE and R_RESP.
  - In R_IDLE, `arready` = 1. On `arvalid`, read data is sampled in that cycle and the FSM moves to R_RESP.
  - In R_RESP, `rvalid` = 1 and `rdata`/`rresp` are held stable. The FSM returns to R_IDLE on `rvalid & rready`.
- The read and write FSMs are independent. If both access the same register in one cycle, the read returns the pre-write value.
- Reset mid-transaction: all state returns to reset values immediately. Outstanding transactions are abandoned with no response.

## Timing
- Write accepted in cycle N:
  - The register holds the new value from N+1.
  - `bvalid` is high from N+1.
  - The next write is accepted no earlier than the cycle after the B handshake.
- Read accepted in cycle N: `rvalid`/`rdata` are valid from N+1.
- Throughput: one read per 2 cycles and one write per 2 cycles, with `bready`/`rready` held high.
- `irq` follows `ie & hit` with 1 cycle of latency:
  - Compare true in cycle N → `irq` = 1 in N+1.
  - A `mtimecmp` write accepted in N that clears `hit` → `irq` = 0 in N+2.
- Backpressure: `bvalid`/`rvalid` stay asserted indefinitely until the matching `ready` is asserted.

## Test plan
- Reset: drive `aresetn` low mid-read. Required: all outputs 0 asynchronously. After release, a read of 0x08 returns 32'hFFFF_FFFF with OKAY.
- Count and prescale: write `PRESCALE` = 3, then `CTRL` = 1, then wait 40 cycles with no bus traffic. Required: `MTIME_LO` reads 10 (±1 for sampling alignment). With `en` = 0, two reads 20 cycles apart return equal values.
- Interrupt:
  - Setup: `mtimecmp` = 50, `CTRL` = 3, `PRESCALE` = 0.
  - Required: `irq` rises exactly 1 cycle after `mtime` reaches 50.
  - Writing `MTIMECMP_LO` = 1000 drops `irq` 2 cycles after write acceptance.
  - Clearing `ie` drops `irq` the same way.
- Wrap and snapshot:
  - Write `MTIME_HI` = 0, then `MTIME_LO` = 32'hFFFF_FFFE, then `CTRL` = 1.
  - Read LO/HI until LO < 32'hFFFF_FFFE (LO has rolled over).
  - Required: HI = 1, and every LO/HI pair is consistent.
- Strobes and errors:
  - Write 32'hAABBCCDD to `MTIMECMP_LO` with `wstrb` = 4'b0101. Required: readback 32'hFFBBFFDD.
  - Write to 0x18. Required: SLVERR.
  - Read 0x1C. Required: 0 with SLVERR.
- Handshake stress:
  - Random `awvalid`/`wvalid` skew, so the two arrive independently: neither is accepted until both are valid.
  - Random `bready`/`rready` stalls: responses are held stable until the handshake completes.
  - Back-to-back mixed traffic: no lost or duplicated responses.
